// File: rtl/pic16c57_io_port.sv
// pic16c57_io_port: one bidirectional PIC16C57 I/O port (PORTA/B/C).
// Holds the output latch and the TRIS direction register. Drives the pins
// from the latch on bits configured as outputs. Conditions incoming pin
// levels with a synchronizer and a per-bit glitch filter before the core
// reads them.
//
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   pin              external port pins (tristate per bit)
//   wr_en, wr_data   port latch write
//   tris_en, tris_data  TRIS register write
//   rd_data          port read value: filtered pin on inputs, latch on outputs
//   tris_q           current TRIS register
//   chg_clr, chg_flag   sticky input-change flag (only with PIC16C57_PORT_CHG_EN)
//
// Optional feature macro: PIC16C57_PORT_CHG_EN
module pic16c57_io_port #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] pin,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             tris_en,
  input  logic [WIDTH-1:0] tris_data,
  output logic [WIDTH-1:0] rd_data,
`ifdef PIC16C57_PORT_CHG_EN
  input  logic             chg_clr,
  output logic             chg_flag,
`endif
  output logic [WIDTH-1:0] tris_q
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN) + 1;

  logic [WIDTH-1:0] latch_q, latch_d;
  logic [WIDTH-1:0] tris_reg, tris_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign tris_q   = tris_reg;

  // Output bits take the latch; input bits take the filtered pin, so
  // read-modify-write instructions never pick up a loaded pin level.
  assign rd_data = (tris_reg & filt_q) | (~tris_reg & latch_q);

  // Per-bit tristate pin driver
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    assign pin[gi] = tris_reg[gi] ? 1'bz : latch_q[gi];
  end

  // Next-state: latch, TRIS, synchronizer chain and glitch filter
  always_comb begin
    latch_d   = wr_en   ? wr_data   : latch_q;
    tris_d    = tris_en ? tris_data : tris_reg;
    sync_d[0] = pin;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != filt_q[i]) begin
        // Accept on the FILTER_LEN-th consecutive differing edge.
        if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
          filt_d[i] = sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q  <= '0;
      tris_reg <= '1;
      filt_q   <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      latch_q  <= latch_d;
      tris_reg <= tris_d;
      filt_q   <= filt_d;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef PIC16C57_PORT_CHG_EN
  logic chg_q, chg_d;

  // Sticky change flag: a filtered change on an input bit beats a clear.
  always_comb begin
    chg_d = chg_q;
    if (|((filt_d ^ filt_q) & tris_reg)) begin
      chg_d = 1'b1;
    end else if (chg_clr) begin
      chg_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign chg_flag = chg_q;
`endif

endmodule

// File: tb/tb_pic16c57_io_port.sv
// tb_pic16c57_io_port: directed bench for pic16c57_io_port.
// u8 (WIDTH=8) covers latch/TRIS/pin drive; u4 (WIDTH=4, PORTA) covers the
// input synchronizer, filter latency, glitch rejection and mid-run reset.
module tb_pic16c57_io_port;

  logic       clk = 1'b0;
  logic       rst;

  logic       wr_en8, tris_en8;
  logic [7:0] wr_data8, tris_data8;
  logic [7:0] rd8, tris8;
  logic [7:0] oe8, drv8;
  wire  [7:0] pin8;

  logic [3:0] rd4, tris4;
  logic [3:0] drv4;
  wire  [3:0] pin4;

`ifdef PIC16C57_PORT_CHG_EN
  logic       clr8, clr4;
  logic       chg8, chg4;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Bench-side pin drivers (only on bits the DUT should not be driving)
  for (genvar gi = 0; gi < 8; gi++) begin : g_drv8
    assign pin8[gi] = oe8[gi] ? drv8[gi] : 1'bz;
  end
  assign pin4 = drv4;

  pic16c57_io_port #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(4)) u8 (
    .clk       (clk),
    .rst       (rst),
    .pin       (pin8),
    .wr_en     (wr_en8),
    .wr_data   (wr_data8),
    .tris_en   (tris_en8),
    .tris_data (tris_data8),
    .rd_data   (rd8),
`ifdef PIC16C57_PORT_CHG_EN
    .chg_clr   (clr8),
    .chg_flag  (chg8),
`endif
    .tris_q    (tris8)
  );

  pic16c57_io_port #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(4)) u4 (
    .clk       (clk),
    .rst       (rst),
    .pin       (pin4),
    .wr_en     (1'b0),
    .wr_data   (4'h0),
    .tris_en   (1'b0),
    .tris_data (4'h0),
    .rd_data   (rd4),
`ifdef PIC16C57_PORT_CHG_EN
    .chg_clr   (clr4),
    .chg_flag  (chg4),
`endif
    .tris_q    (tris4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
    tests++;
    assert (obs === want) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  initial begin
    rst        = 1'b1;
    wr_en8     = 1'b0;
    tris_en8   = 1'b0;
    wr_data8   = 8'h00;
    tris_data8 = 8'h00;
    oe8        = 8'hFF;
    drv8       = 8'h00;
    drv4       = 4'h0;
`ifdef PIC16C57_PORT_CHG_EN
    clr8 = 1'b0;
    clr4 = 1'b0;
`endif

    // Reset
    step();
    rst = 1'b0;
    check("reset_tris8", tris8, 8'hFF);
    check("reset_rd8", rd8, 8'h00);
    check("reset_tris4", 8'(tris4), 8'h0F);
    check("reset_rd4", 8'(rd4), 8'h00);
`ifdef PIC16C57_PORT_CHG_EN
    check("reset_chg8", 8'(chg8), 8'h00);
    check("reset_chg4", 8'(chg4), 8'h00);
`endif
    // Latch is 0 after reset: pins must follow the bench, not the latch.
    drv8 = 8'hFF;
    #1;
    check("reset_pin_z", pin8, 8'hFF);
    drv8 = 8'h00;

    // Output drive
    tris_en8 = 1'b1; tris_data8 = 8'h00;
    step();
    tris_en8 = 1'b0; oe8 = 8'h00;
    check("tris_out", tris8, 8'h00);
    wr_en8 = 1'b1; wr_data8 = 8'hA5;
    step();
    wr_en8 = 1'b0;
    check("drive_pin", pin8, 8'hA5);
    check("drive_rd_latch", rd8, 8'hA5);

    // Back to inputs: rd_data selects the filter, which has not seen A5 yet.
    tris_en8 = 1'b1; tris_data8 = 8'hFF; oe8 = 8'hFF; drv8 = 8'hA5;
    step();
    tris_en8 = 1'b0;
    check("tris_in", tris8, 8'hFF);
    check("rd_filt_select", rd8, 8'h00);

    // Deferred drive: latch written while all inputs
    wr_en8 = 1'b1; wr_data8 = 8'h3C; drv8 = 8'hC3;
    step();
    wr_en8 = 1'b0;
    check("defer_pin_z", pin8, 8'hC3);
    tris_en8 = 1'b1; tris_data8 = 8'hF0; drv8 = 8'h5C;
    step();
    tris_en8 = 1'b0; oe8 = 8'hF0;
    check("defer_tris", tris8, 8'hF0);
    check("defer_pin_mix", pin8, 8'h5C);
    repeat (8) step();
    check("mixed_rd", rd8, 8'h5C);

    // Input latency, rising
    drv4 = 4'h1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("rise_rd_e%0d", k), 8'(rd4), (k == 6) ? 8'h01 : 8'h00);
`ifdef PIC16C57_PORT_CHG_EN
      check($sformatf("rise_chg_e%0d", k), 8'(chg4), (k == 6) ? 8'h01 : 8'h00);
`endif
    end

    // Input latency, falling; clear alone, then clear colliding with a change
    drv4 = 4'h0;
    for (int k = 1; k <= 6; k++) begin
`ifdef PIC16C57_PORT_CHG_EN
      clr4 = (k == 1) || (k == 6);
`endif
      step();
`ifdef PIC16C57_PORT_CHG_EN
      clr4 = 1'b0;
      check($sformatf("fall_chg_e%0d", k), 8'(chg4), (k == 6) ? 8'h01 : 8'h00);
`endif
      check($sformatf("fall_rd_e%0d", k), 8'(rd4), (k == 6) ? 8'h00 : 8'h01);
    end
`ifdef PIC16C57_PORT_CHG_EN
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    check("chg_clr_alone", 8'(chg4), 8'h00);
`endif

    // 3-cycle glitch is rejected
    drv4 = 4'h1;
    repeat (3) step();
    drv4 = 4'h0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("glitch3_e%0d", k), 8'(rd4), 8'h00);
    end
`ifdef PIC16C57_PORT_CHG_EN
    check("glitch3_chg", 8'(chg4), 8'h00);
`endif

    // 4-cycle pulse passes: up after edge 6, down after edge 10
    for (int k = 1; k <= 10; k++) begin
      drv4 = (k <= 4) ? 4'h1 : 4'h0;
      step();
      check($sformatf("pulse4_e%0d", k), 8'(rd4), (k >= 6 && k <= 9) ? 8'h01 : 8'h00);
    end
`ifdef PIC16C57_PORT_CHG_EN
    check("pulse4_chg", 8'(chg4), 8'h01);
`endif

    // Reset in the middle of a pending filter count
    drv4 = 4'h1;
    repeat (4) step();
    oe8 = 8'hFF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_tris8", tris8, 8'hFF);
    check("midrst_rd8", rd8, 8'h00);
    check("midrst_rd4", 8'(rd4), 8'h00);
`ifdef PIC16C57_PORT_CHG_EN
    check("midrst_chg4", 8'(chg4), 8'h00);
`endif
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("midrst_e%0d", k), 8'(rd4), (k == 6) ? 8'h01 : 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pic16c57_io_port.md
Name: pic16c57_io_port

Overview:
- One bidirectional I/O port (PORTA/PORTB/PORTC) of the PIC16C57 core.
- Sits between the external pins (RA/RB/RC) and the core's register-file bus.
- Holds the port output latch and the TRIS direction register.
- Conditions incoming pin levels with a synchronizer and a per-bit glitch filter before the core reads them.
- Instantiated three times: WIDTH=4 for RA, WIDTH=8 for RB and RC.

Parameters:
- WIDTH, 8: number of port bits (4 for PORTA).
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer; minimum 2.
- FILTER_LEN, 4: consecutive cycles a synchronized input must differ from the filtered value before it is accepted; minimum 1 (1 = no filtering).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- pin  inout  WIDTH  external port pins.
- wr_en  input  1  write port latch (MOVWF/BSF/BCF to PORTx).
- wr_data  input  WIDTH  latch write data.
- tris_en  input  1  TRIS instruction strobe for this port.
- tris_data  input  WIDTH  new TRIS value (W register).
- rd_data  output  WIDTH  port read value to the core.
- tris_q  output  WIDTH  current TRIS register (debug/visibility).

Behaviour:
- Reset (rst=1 sampled on a clk rising edge):
  - tris <= all ones (all inputs); latch <= 0; all synchronizer stages <= 0; filtered value <= 0; all filter counters <= 0.
  - Consequently pin = all Z, rd_data = 0, tris_q = all ones.
  - Reset mid-operation aborts any pending filter count; values return to their reset state on that edge.
- Latch write: wr_en=1 at edge N -> latch = wr_data after edge N. The latch is written regardless of TRIS.
- TRIS write: tris_en=1 at edge N -> tris = tris_data after edge N.
- wr_en and tris_en in the same cycle: both registers update on that edge, independently.
- Pin drive (combinational from registers): pin[i] = latch[i] when tris[i]=0, else Z.
  - A latch written while tris[i]=1 appears on the pin the cycle after tris[i] is cleared.
- Input path, per bit:
  - The pin is sampled into a SYNC_STAGES-deep shift chain; sync_out = last stage.
  - The filter counter resets to 0 whenever sync_out == filt.
  - Otherwise the counter increments. On the FILTER_LEN-th consecutive differing edge, filt <= sync_out and the counter <= 0.
  - Counter width = clog2(FILTER_LEN)+1. The counter never wraps.
  - A glitch shorter than FILTER_LEN cycles at sync_out never reaches filt.
- Latency:
  - A stable pin change is visible on filt, and thus rd_data, after exactly SYNC_STAGES+FILTER_LEN rising edges, counting the first edge that samples the new level.
  - With defaults this is 6 edges.
- Read: rd_data[i] = filt[i] when tris[i]=1; rd_data[i] = latch[i] when tris[i]=0.
  - The output branch avoids read-modify-write hazards.
  - rd_data is combinational from registers and has no read strobe.
- Switching a bit from output to input:
  - The filter keeps running on the pin at all times, so no reset of filter state occurs.
  - rd_data[i] immediately selects the current filt[i].
- Undriven input pins are the bench's or board's responsibility. X on pin propagates through the synchronizer unfiltered-for-X.

Optional Feature:
- Macro: PIC16C57_PORT_CHG_EN.
- Defined:
  - Adds input port chg_clr (1) and output port chg_flag (1).
  - chg_flag is sticky. It is set on any edge where filt[i] changes for a bit with tris[i]=1.
  - It is cleared by chg_clr=1. If set and clear occur in the same cycle, set wins.
  - Reset value 0.
  - Bits with tris[i]=0 never set the flag.
- Not defined: neither port exists, no flag logic is generated, and all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 1 edge -> tris_q=0xFF, pin=ZZZZZZZZ, rd_data=0x00; any pending filter count is discarded.
- Output drive: tris_en with tris_data=0x00, then wr_en with wr_data=0xA5 -> pin=0xA5 one edge after the write; rd_data=0xA5 immediately.
- Deferred drive: with tris=0xFF, write latch=0x3C -> pin stays Z; then tris_data=0xF0 -> pin[3:0]=0xC one edge later and pin[7:4]=Z.
- Input latency (WIDTH=4, defaults): drive RA=0x1 between edges -> rd_data=0x0 through edge 5 and rd_data=0x1 after edge 6; drive RA=0x0 -> rd_data=0x0 after 6 further edges.
- Glitch reject: pulse pin[0] high for 3 cycles -> rd_data[0] stays 0. Pulse it for 4 cycles -> rd_data[0]=1 after edge 6.
- Change flag (PIC16C57_PORT_CHG_EN): an input toggle sets chg_flag after 6 edges. Assert chg_clr on the same edge as a new filt change -> chg_flag stays 1. chg_clr alone -> chg_flag=0.
